door_bank_ctrl: RTL and testbench

Parametrised automatic door controller driving N_LEAF motorised door leaves from one shared state machine, with a programmable auto-close hold timer, obstruction reopen, lock/bolt control and a configurable failed-manual-open alarm. It sits between the sensor front end (approach, presence, manual-open, lock switch, per-leaf limit switches) and the motor drivers. It replaces the fixed two-leaf, fixed-three-attempt controller in the door subsystem.

---
 rtl/door_pkg.sv | 23 ++
 rtl/door_bank_ctrl_if.sv | 35 +++
 rtl/door_attempt_counter.sv | 55 +++++
 rtl/door_bank_ctrl.sv | 90 +++++++++
 tb/tb_door_bank_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/door_pkg.sv
`default_nettype none
// ============================================================================
// Module   : door_pkg
// Brief    : Shared state encoding and counter-width helper for the door bank.
// Revision : 1.0
// ============================================================================
package door_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED    = 3'd0,
        ST_OPENING   = 3'd1,
        ST_OPEN_HOLD = 3'd2,
        ST_CLOSING   = 3'd3,
        ST_LOCKED    = 3'd4
    } door_state_t;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/door_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : door_bank_ctrl_if
// Brief    : Sensor inputs and motor/status outputs of the door bank controller.
// Revision : 1.0
// ============================================================================
interface door_bank_ctrl_if #(
    parameter int N_LEAF = 2,
    parameter int ATT_W  = 2
);
    logic              pa;
    logic              pp;
    logic              mo;
    logic              lock;
    logic              alarm_clr;
    logic [N_LEAF-1:0] open_lim;
    logic [N_LEAF-1:0] closed_lim;
    logic [N_LEAF-1:0] motor_open;
    logic [N_LEAF-1:0] motor_close;
    logic              bolt;
    logic              alarm;
    logic [2:0]        state;
    logic [ATT_W-1:0]  attempts;

    modport master (
        output pa, pp, mo, lock, alarm_clr, open_lim, closed_lim,
        input  motor_open, motor_close, bolt, alarm, state, attempts
    );

    modport slave (
        input  pa, pp, mo, lock, alarm_clr, open_lim, closed_lim,
        output motor_open, motor_close, bolt, alarm, state, attempts
    );
endinterface
`default_nettype wire

// File: rtl/door_attempt_counter.sv
`default_nettype none
// ============================================================================
// Module   : door_attempt_counter
// Brief    : Counts manual-open edges while locked and raises a sticky alarm.
// Revision : 1.0
// ============================================================================
module door_attempt_counter
    import door_pkg::*;
#(
    parameter  int MAX_ATTEMPTS = 3,
    localparam int ATT_W        = cnt_width(MAX_ATTEMPTS)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             mo,
    input  wire logic             locked,
    input  wire logic             alarm_clr,
    output logic      [ATT_W-1:0] attempts,
    output logic                  alarm
);
    localparam logic [ATT_W-1:0] c_MAX = ATT_W'(MAX_ATTEMPTS);
    localparam logic [ATT_W-1:0] c_ONE = ATT_W'(1);

    logic             r_mo_q;
    logic [ATT_W-1:0] r_attempts;
    logic             r_alarm;
    logic             w_edge;

    assign w_edge = mo & ~r_mo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mo_q     <= 1'b0;
            r_attempts <= '0;
            r_alarm    <= 1'b0;
        end else begin
            r_mo_q <= mo;
            // A clear wins over an attempt landing in the same cycle.
            if (alarm_clr) begin
                r_attempts <= '0;
                r_alarm    <= 1'b0;
            end else if (w_edge && locked && (r_attempts != c_MAX)) begin
                r_attempts <= r_attempts + c_ONE;
                if ((r_attempts + c_ONE) == c_MAX) begin
                    r_alarm <= 1'b1;
                end
            end
        end
    end

    assign attempts = r_attempts;
    assign alarm    = r_alarm;

endmodule
`default_nettype wire

// File: rtl/door_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : door_bank_ctrl
// Brief    : Shared FSM, hold timer and per-leaf motor decode for N_LEAF doors.
// Revision : 1.0
// ============================================================================
module door_bank_ctrl
    import door_pkg::*;
#(
    parameter int N_LEAF       = 2,
    parameter int HOLD_CYCLES  = 16,
    parameter int MAX_ATTEMPTS = 3
) (
    input  wire logic    clk,
    input  wire logic    reset,
    door_bank_ctrl_if.slave bus
);
    localparam int                c_TMR_W = cnt_width(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LOAD = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);

    door_state_t        r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic               w_req;
    logic [N_LEAF-1:0]  w_motor_open;
    logic [N_LEAF-1:0]  w_motor_close;

    assign w_req = bus.pa | bus.pp | bus.mo;

    // Reset lands in CLOSING so any ajar leaf is driven shut on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLOSING;
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_CLOSED: begin
                    if (bus.lock)   r_state <= ST_LOCKED;
                    else if (w_req) r_state <= ST_OPENING;
                end
                ST_OPENING: begin
                    if (&bus.open_lim) begin
                        r_state <= ST_OPEN_HOLD;
                        r_timer <= c_HOLD_LOAD;
                    end
                end
                ST_OPEN_HOLD: begin
                    if (w_req)               r_timer <= c_HOLD_LOAD;
                    else if (r_timer == '0)  r_state <= ST_CLOSING;
                    else                     r_timer <= r_timer - c_TMR_ONE;
                end
                ST_CLOSING: begin
                    if (w_req)                 r_state <= ST_OPENING;
                    else if (&bus.closed_lim)  r_state <= ST_CLOSED;
                end
                ST_LOCKED: begin
                    if (!bus.lock) r_state <= ST_CLOSED;
                end
                default: r_state <= ST_CLOSING;
            endcase
        end
    end

    // A leaf reporting both limits is treated as faulty and left undriven.
    for (genvar i = 0; i < N_LEAF; i++) begin : g_leaf
        logic w_both;
        assign w_both          = bus.open_lim[i] & bus.closed_lim[i];
        assign w_motor_open[i]  = ~reset & ~w_both & (r_state == ST_OPENING) & ~bus.open_lim[i];
        assign w_motor_close[i] = ~reset & ~w_both & (r_state == ST_CLOSING) & ~bus.closed_lim[i];
    end

    door_attempt_counter #(
        .MAX_ATTEMPTS (MAX_ATTEMPTS)
    ) u_attempts (
        .clk       (clk),
        .reset     (reset),
        .mo        (bus.mo),
        .locked    (r_state == ST_LOCKED),
        .alarm_clr (bus.alarm_clr),
        .attempts  (bus.attempts),
        .alarm     (bus.alarm)
    );

    assign bus.motor_open  = w_motor_open;
    assign bus.motor_close = w_motor_close;
    assign bus.bolt        = ~reset & (r_state == ST_LOCKED);
    assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_door_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_door_bank_ctrl
// Brief    : Directed scoreboard bench for a 2-leaf and a 3-leaf door bank.
// Revision : 1.0
// ============================================================================
module tb_door_bank_ctrl;
    import door_pkg::*;

    localparam int c_ATT_W = cnt_width(3);

    logic clk;
    logic reset;

    door_bank_ctrl_if #(.N_LEAF(2), .ATT_W(c_ATT_W)) a ();
    door_bank_ctrl_if #(.N_LEAF(3), .ATT_W(c_ATT_W)) b ();

    door_bank_ctrl #(.N_LEAF(2), .HOLD_CYCLES(4), .MAX_ATTEMPTS(3)) dut2 (
        .clk (clk), .reset (reset), .bus (a)
    );
    door_bank_ctrl #(.N_LEAF(3), .HOLD_CYCLES(4), .MAX_ATTEMPTS(3)) dut3 (
        .clk (clk), .reset (reset), .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h expected nothing queued", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a.pa = 0; a.pp = 0; a.mo = 0; a.lock = 0; a.alarm_clr = 0;
        a.open_lim = 2'b00; a.closed_lim = 2'b11;
        b.pa = 0; b.pp = 0; b.mo = 0; b.lock = 0; b.alarm_clr = 0;
        b.open_lim = 3'b000; b.closed_lim = 3'b111;

        // Reset state
        push("rst_state", 3); push("rst_mclose", 0); push("rst_bolt", 0);
        push("rst_alarm", 0); push("rst_attempts", 0);
        tick(); tick();
        chk(32'(a.state)); chk(32'(a.motor_close)); chk(32'(a.bolt));
        chk(32'(a.alarm)); chk(32'(a.attempts));

        reset = 1'b0;
        push("post_rst_closed", 0); push("post_rst_closed3", 0);
        tick();
        chk(32'(a.state)); chk(32'(b.state));

        // Approach opens both leaves
        a.pa = 1; a.closed_lim = 2'b00;
        push("open_state", 1); push("open_motor", 3);
        tick();
        chk(32'(a.state)); chk(32'(a.motor_open));
        a.pa = 0;
        tick(); tick();
        a.open_lim = 2'b01; #1;
        push("leaf0_open_motor", 2);
        chk(32'(a.motor_open));
        a.open_lim = 2'b11;
        push("hold_state", 2); push("hold_motor", 0);
        tick();
        chk(32'(a.state)); chk(32'(a.motor_open));
        push("hold_still", 2);
        tick(); tick(); tick();
        chk(32'(a.state));
        push("hold_expire", 3);
        tick();
        chk(32'(a.state));
        a.open_lim = 2'b00; #1;
        push("closing_motor", 3);
        chk(32'(a.motor_close));

        // Presence during closing reopens
        a.closed_lim = 2'b01; #1;
        push("closing_partial", 2);
        chk(32'(a.motor_close));
        a.pp = 1;
        push("reopen_state", 1); push("reopen_mclose", 0); push("reopen_mopen", 3);
        tick();
        chk(32'(a.state)); chk(32'(a.motor_close)); chk(32'(a.motor_open));
        a.pp = 0; a.closed_lim = 2'b00; a.open_lim = 2'b11;
        tick(); tick(); tick(); tick(); tick();
        a.open_lim = 2'b00; a.closed_lim = 2'b11;
        push("reclosed", 0);
        tick();
        chk(32'(a.state));

        // Lock beats request
        a.lock = 1; a.pa = 1;
        push("locked_state", 4); push("locked_bolt", 1); push("locked_mopen", 0);
        tick();
        chk(32'(a.state)); chk(32'(a.bolt)); chk(32'(a.motor_open));
        a.pa = 0;

        // Manual-open attempts while locked
        for (int n = 1; n <= 4; n++) begin
            a.mo = 1;
            push("attempts", (n > 3) ? 3 : n);
            push("alarm", (n >= 3) ? 1 : 0);
            tick();
            chk(32'(a.attempts)); chk(32'(a.alarm));
            a.mo = 0;
            tick();
        end
        a.lock = 0;
        push("unlock_state", 0); push("unlock_alarm", 1); push("unlock_bolt", 0);
        tick();
        chk(32'(a.state)); chk(32'(a.alarm)); chk(32'(a.bolt));
        a.alarm_clr = 1;
        push("clr_alarm", 0); push("clr_attempts", 0);
        tick();
        chk(32'(a.alarm)); chk(32'(a.attempts));
        a.alarm_clr = 0;

        // Reset in the middle of opening
        a.pa = 1; a.closed_lim = 2'b00; a.open_lim = 2'b00;
        push("midopen_state", 1);
        tick();
        chk(32'(a.state));
        a.pa = 0; reset = 1;
        push("rst_mid_mopen", 0); push("rst_mid_mclose", 0);
        tick();
        chk(32'(a.motor_open)); chk(32'(a.motor_close));
        reset = 0; #1;
        push("rel_state", 3); push("rel_mclose", 3);
        chk(32'(a.state)); chk(32'(a.motor_close));

        // Three leaves reaching their open limits at different times
        b.pa = 1; b.closed_lim = 3'b000;
        push("b_open_motor", 7);
        tick();
        chk(32'(b.motor_open));
        b.pa = 0; b.open_lim = 3'b001; #1;
        push("b_leaf0", 6);
        chk(32'(b.motor_open));
        push("b_still_opening", 1);
        tick();
        chk(32'(b.state));
        b.open_lim = 3'b111; #1;
        push("b_all_open_motor", 0); push("b_not_hold_yet", 1);
        chk(32'(b.motor_open)); chk(32'(b.state));
        push("b_hold", 2);
        tick();
        chk(32'(b.state));

        if (q.size() != 0) begin
            n_total++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
